// File: rtl/alu_multicycle.sv
// Registered RV32I ALU with valid/ready handshakes, iterative shift-add MUL and restoring DIVU/REMU.
// Define ALU_SIGNED_DIV_EN to add signed DIV (1110) and REM (1111) on top of the unsigned divider.

module alu_multicycle #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     busy
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] ITERS = CW'(DATA_WIDTH);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = OPCODE_LENGTH'(4'b1101);
`ifdef ALU_SIGNED_DIV_EN
  localparam logic [OPCODE_LENGTH-1:0] OP_DIV  = OPCODE_LENGTH'(4'b1110);
  localparam logic [OPCODE_LENGTH-1:0] OP_REM  = OPCODE_LENGTH'(4'b1111);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                     state;
  logic [OPCODE_LENGTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0]      opd;   // multiplicand (MUL) or divisor magnitude (DIV)
  logic [DATA_WIDTH-1:0]      acc;   // product accumulator or partial remainder
  logic [DATA_WIDTH-1:0]      quo;   // multiplier bits or dividend/quotient shift register
  logic [CW-1:0]              cnt;

  logic [SHW-1:0]             shamt;
  logic [DATA_WIDTH-1:0]      single_res;
  logic                       is_mul, is_div, div_zero, div_ovf;
  logic [DATA_WIDTH-1:0]      a_mag, b_mag;
  logic [DATA_WIDTH-1:0]      rem_shift;
  logic [DATA_WIDTH:0]        div_diff;
  logic [DATA_WIDTH-1:0]      div_res;
`ifdef ALU_SIGNED_DIV_EN
  logic                       is_sdiv, a_neg, b_neg, neg_q, neg_r;
`endif

  assign shamt    = SrcB[SHW-1:0];
  assign in_ready = (state == S_IDLE);

  // NOTE: every variable an always_comb writes gets a default first, so no path can infer a latch.
  always_comb begin
    single_res = '0;
    case (Operation)
      OP_AND:  single_res = SrcA & SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_ADD:  single_res = SrcA + SrcB;
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_EQ:   single_res = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: single_res = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
      OP_SLL:  single_res = SrcA << shamt;
      OP_SRL:  single_res = SrcA >> shamt;
      OP_SRA:  single_res = $signed(SrcA) >>> shamt;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    is_mul   = (Operation == OP_MUL);
    is_div   = (Operation == OP_DIVU) || (Operation == OP_REMU);
    div_zero = (SrcB == '0);
    div_ovf  = 1'b0;
    a_mag    = SrcA;
    b_mag    = SrcB;
`ifdef ALU_SIGNED_DIV_EN
    is_sdiv = (Operation == OP_DIV) || (Operation == OP_REM);
    a_neg   = is_sdiv && SrcA[DATA_WIDTH-1];
    b_neg   = is_sdiv && SrcB[DATA_WIDTH-1];
    if (is_sdiv) is_div = 1'b1;
    if (a_neg)   a_mag = -SrcA;
    if (b_neg)   b_mag = -SrcB;
    div_ovf = is_sdiv && (SrcA == MOST_NEG) && (SrcB == '1);
`endif
  end

  // One restoring step: shift the next dividend bit into the remainder and try to subtract.
  always_comb begin
    rem_shift = {acc[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
    div_diff  = {acc[DATA_WIDTH-1], rem_shift} - {1'b0, opd};
    div_res   = (op_q == OP_REMU) ? acc : quo;
`ifdef ALU_SIGNED_DIV_EN
    if (op_q == OP_DIV)      div_res = neg_q ? -quo : quo;
    else if (op_q == OP_REM) div_res = neg_r ? -acc : acc;
`endif
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the asynchronous reset clears the datapath registers too; an aborted op leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      opd       <= '0;
      acc       <= '0;
      quo       <= '0;
      cnt       <= '0;
      ALUResult <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ALU_SIGNED_DIV_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q <= Operation;
          cnt  <= '0;
          acc  <= '0;
          if (is_mul) begin
            opd   <= SrcA;
            quo   <= SrcB;
            busy  <= 1'b1;
            state <= S_MUL;
          end else if (is_div) begin
            busy  <= 1'b1;
            state <= S_DIV;
            // Special cases skip the iterations and finalise on the next edge.
            if (div_zero) begin
              cnt <= ITERS;
              quo <= '1;
              acc <= SrcA;
            end else if (div_ovf) begin
              cnt <= ITERS;
              quo <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
              opd <= b_mag;
              quo <= a_mag;
            end
`ifdef ALU_SIGNED_DIV_EN
            neg_q <= (a_neg ^ b_neg) && !div_zero && !div_ovf;
            neg_r <= a_neg && !div_zero && !div_ovf;
`endif
          end else begin
            ALUResult <= single_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_MUL: begin
          if (cnt == ITERS) begin
            ALUResult <= acc;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            if (quo[0]) acc <= acc + opd;
            opd <= opd << 1;
            quo <= quo >> 1;
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (cnt == ITERS) begin
            ALUResult <= div_res;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            if (!div_diff[DATA_WIDTH]) begin
              acc <= div_diff[DATA_WIDTH-1:0];
              quo <= {quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
              acc <= rem_shift;
              quo <= {quo[DATA_WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle: handshake, latency, arithmetic results, flush and reset abort.
// Compile with ALU_SIGNED_DIV_EN to exercise signed division instead of the unassigned-opcode case.

module tb_alu_multicycle;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;
  localparam logic [3:0] OP_X14  = 4'b1110;
  localparam logic [3:0] OP_X15  = 4'b1111;

  logic         clk, reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [W-1:0] SrcA, SrcB, ALUResult;
  logic [3:0]   Operation;

  int checks   = 0;
  int failures = 0;

  alu_multicycle #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, returns the result and the number of edges after accept until out_valid (-1 = timeout).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
    for (int g = 0; g < 50 && !in_ready; g++) tick();
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    lat = -1;
    for (int i = 0; i <= 100; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      tick();
    end
    res = ALUResult;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (ALUResult !== '0) begin failures++; $display("FAIL reset_result: got %h want 0", ALUResult); end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    Operation = OP_ADD;
    SrcA      = 32'h7FFF_FFFF;
    SrcB      = 32'h0000_0001;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
    checks++;
    if (ALUResult !== 32'h8000_0000) begin failures++; $display("FAIL add_result: got %h want 80000000", ALUResult); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready_done: got %b want 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready_back: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL add_out_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]   ops  [12] = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_EQ,
                                OP_EQ, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};
    logic [W-1:0] va   [12] = '{32'hF0F0_1234, 32'hF000_000F, 32'hAAAA_5555, 32'hFFFF_FFFF,
                                32'h0000_0000, 32'h0000_0005, 32'h0000_0005, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0] vb   [12] = '{32'h0FF0_FF00, 32'h0000_F0F0, 32'hFFFF_0000, 32'h0000_0002,
                                32'h0000_0001, 32'h0000_0005, 32'h0000_0006, 32'h0000_0001,
                                32'h0000_0001, 32'h0000_001F, 32'h0000_0024, 32'h0000_001F};
    logic [W-1:0] vexp [12] = '{32'h00F0_1200, 32'hF000_F0FF, 32'h5555_5555, 32'h0000_0001,
                                32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001,
                                32'h0000_0000, 32'h8000_0000, 32'h0800_0000, 32'hFFFF_FFFF};
    logic [W-1:0] res;
    int lat;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], va[i], vb[i], res, lat);
      checks++;
      if (res !== vexp[i]) begin
        failures++;
        $display("FAIL single_result[%0d] op=%b: got %h want %h", i, ops[i], res, vexp[i]);
      end
      checks++;
      if (lat !== 0) begin failures++; $display("FAIL single_latency[%0d]: got %0d want 0", i, lat); end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] res;
    int lat;
    Operation = OP_MUL;
    SrcA      = 32'h0001_2345;
    SrcB      = 32'h0000_1000;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    // Later operand changes must not affect the latched operation.
    SrcA      = 32'hDEAD_BEEF;
    Operation = OP_ADD;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy_start: got %b want 1", busy); end
    lat = -1;
    for (int i = 0; i <= 100; i++) begin
      if (out_valid) begin lat = i; break; end
      tick();
    end
    checks++;
    if (lat !== W + 1) begin failures++; $display("FAIL mul_latency: got %0d want %0d", lat, W + 1); end
    checks++;
    if (ALUResult !== 32'h1234_5000) begin failures++; $display("FAIL mul_result: got %h want 12345000", ALUResult); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_end: got %b want 0", busy); end
    tick();
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0003, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL mul_neg_wrap: got %h want fffffffd", res); end
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, res, lat);
    checks++;
    if (res !== 32'h0000_0000) begin failures++; $display("FAIL mul_overflow_low: got %h want 0", res); end
  endtask

  task automatic test_div();
    logic [3:0]   ops  [7] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIVU};
    logic [W-1:0] va   [7] = '{32'd100, 32'd100, 32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
    logic [W-1:0] vb   [7] = '{32'd7,   32'd7,   32'd0,   32'd0,   32'd1,        32'd10,       32'd5};
    logic [W-1:0] vexp [7] = '{32'd14,  32'd2,   32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 32'd5, 32'd0};
    int           vlat [7] = '{33, 33, 1, 1, 33, 33, 33};
    logic [W-1:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], va[i], vb[i], res, lat);
      checks++;
      if (res !== vexp[i]) begin
        failures++;
        $display("FAIL div_result[%0d] op=%b: got %h want %h", i, ops[i], res, vexp[i]);
      end
      checks++;
      if (lat !== vlat[i]) begin failures++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, vlat[i]); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    Operation = OP_SRA;
    SrcA      = 32'h8000_0000;
    SrcB      = 32'h0000_0004;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      checks++;
      if (ALUResult !== 32'hF800_0000) begin failures++; $display("FAIL bp_result[%0d]: got %h want f8000000", i, ALUResult); end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    checks++;
    if (ALUResult !== 32'hF800_0000) begin failures++; $display("FAIL bp_result_kept: got %h want f8000000", ALUResult); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    out_ready = 1'b1;
    Operation = OP_ADD;
    SrcA      = 32'd1;
    SrcB      = 32'd1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) done_cnt++;
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt !== 4) begin failures++; $display("FAIL b2b_throughput: got %0d results in 8 cycles want 4", done_cnt); end
    checks++;
    if (ALUResult !== 32'd2) begin failures++; $display("FAIL b2b_result: got %h want 2", ALUResult); end
    tick();
  endtask

  task automatic test_flush();
    int late_valid = 0;
    Operation = OP_DIVU;
    SrcA      = 32'd100;
    SrcB      = 32'd7;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (10) tick();
    // A new op offered together with flush must be dropped.
    flush     = 1'b1;
    in_valid  = 1'b1;
    Operation = OP_ADD;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle: got in_ready=%b want 1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) late_valid++;
    end
    checks++;
    if (late_valid !== 0) begin failures++; $display("FAIL flush_no_result: got %0d valid cycles want 0", late_valid); end
  endtask

  task automatic test_opt_opcodes();
    logic [W-1:0] res;
    int lat;
`ifdef ALU_SIGNED_DIV_EN
    logic [3:0]   ops  [10] = '{OP_X14, OP_X15, OP_X14, OP_X15, OP_X14, OP_X15, OP_X14, OP_X15, OP_X14, OP_X15};
    logic [W-1:0] va   [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd7,
                                32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [W-1:0] vb   [10] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                                32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [W-1:0] vexp [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFD,
                                32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF};
    int           vlat [10] = '{33, 33, 1, 1, 33, 33, 1, 1, 33, 33};
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], va[i], vb[i], res, lat);
      checks++;
      if (res !== vexp[i]) begin
        failures++;
        $display("FAIL sdiv_result[%0d] op=%b: got %h want %h", i, ops[i], res, vexp[i]);
      end
      checks++;
      if (lat !== vlat[i]) begin failures++; $display("FAIL sdiv_latency[%0d]: got %0d want %0d", i, lat, vlat[i]); end
    end
`else
    run_op(OP_ADD, 32'd5, 32'd6, res, lat);
    checks++;
    if (res !== 32'd11) begin failures++; $display("FAIL unassigned_setup: got %h want b", res); end
    run_op(OP_X14, 32'hFFFF_FFF9, 32'd2, res, lat);
    checks++;
    if (res !== 32'd0) begin failures++; $display("FAIL unassigned_1110_result: got %h want 0", res); end
    checks++;
    if (lat !== 0) begin failures++; $display("FAIL unassigned_1110_latency: got %0d want 0", lat); end
    run_op(OP_X15, 32'h1234_5678, 32'd3, res, lat);
    checks++;
    if (res !== 32'd0) begin failures++; $display("FAIL unassigned_1111_result: got %h want 0", res); end
`endif
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] res;
    int lat;
    run_op(OP_ADD, 32'h1111_1111, 32'h2222_2222, res, lat);
    Operation = OP_MUL;
    SrcA      = 32'd9;
    SrcB      = 32'd9;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    checks++;
    if (ALUResult !== '0) begin failures++; $display("FAIL rstmid_result: got %h want 0", ALUResult); end
    #2;
    reset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    repeat (40) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_result: got %b want 0", out_valid); end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    SrcA      = '0;
    SrcB      = '0;
    Operation = '0;
    test_reset();
    test_add();
    test_single_cycle();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_opt_opcodes();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
